// File: rtl/apb_pkg.sv
// APB register file: shared FSM encoding and wait-counter width.
// Imported by apb_regfile.
package apb_pkg;
   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WAIT,
      ACCESS
   } state_t;

   localparam int WAIT_W = 4;
endpackage

// File: rtl/apb_regbank.sv
// APB register file storage: NREG x DATA_W array.
// Write port skips read-only and out-of-range registers.
module apb_regbank #(
   parameter int              DATA_W  = 8,
   parameter int              ADDR_W  = 8,
   parameter int              NREG    = 16,
   parameter logic [NREG-1:0] RO_MASK = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NREG);

   logic [DATA_W-1:0] mem [NREG];
   logic [IW-1:0]     widx;
   logic [IW-1:0]     ridx;
   logic              wok;

   assign widx = waddr[IW-1:0];
   assign ridx = raddr[IW-1:0];
   assign wok  = ({1'b0, waddr} < LIM) && !RO_MASK[widx];

   // register array: cleared on reset, written when the slot is writable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we && wok) begin
         mem[widx] <= wdata;
      end
   end

   // read port returns zero for addresses past the array
   always_comb begin
      rdata = '0;
      if ({1'b0, raddr} < LIM) begin
         rdata = mem[ridx];
      end
   end
endmodule

// File: rtl/apb_regfile.sv
// APB slave register file: FSM, wait states, response logic.
// Define APB_REGFILE_WAIT_EN to add WAIT_CYC wait states per access.
module apb_regfile
   import apb_pkg::*;
#(
   parameter int              DATA_W   = 8,
   parameter int              ADDR_W   = 8,
   parameter int              NREG     = 16,
   parameter logic [NREG-1:0] RO_MASK  = '0,
   parameter int              WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic              pwrite,
   input  logic              psel,
   input  logic              penable,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);
   localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NREG);

   if (NREG < 1 || NREG > 2**ADDR_W ||
       WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_param
      $error("apb_regfile: illegal parameters");
   end

   state_t            state;
   state_t            cur;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] prdata_q;
   logic [DATA_W-1:0] rdata;
   logic              wr_q;
   logic              err_q;
   logic              we;
   logic              setup_c;
   logic              acc_c;
   logic              err_c;

   assign setup_c = psel & ~penable;
   assign acc_c   = psel & penable;
   assign err_c   = ({1'b0, addr} >= LIM) |
                    (pwrite & RO_MASK[addr[IW-1:0]]);

`ifdef APB_REGFILE_WAIT_EN
   logic [WAIT_W-1:0] cnt;
   logic              wait_done;

   assign wait_done = (cnt == WAIT_W'(WAIT_CYC));

   // number of wait cycles already spent in this transfer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         cnt <= (cur == WAIT) ? cnt + 1'b1 : '0;
      end
   end
`endif

   // state register: bus phase seen in the previous cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= cur;
      end
   end

   // phase of the current cycle; anything off-protocol falls back
   always_comb begin
      cur = setup_c ? SETUP : IDLE;
      unique case (state)
         SETUP: begin
            if (acc_c) begin
`ifdef APB_REGFILE_WAIT_EN
               cur = (WAIT_CYC != 0) ? WAIT : ACCESS;
`else
               cur = ACCESS;
`endif
            end
         end
`ifdef APB_REGFILE_WAIT_EN
         WAIT: begin
            if (acc_c) begin
               cur = wait_done ? ACCESS : WAIT;
            end
         end
`endif
         default: ;
      endcase
   end

   // response: prdata only moves to the new value on a read
   always_comb begin
      pready  = (cur == ACCESS);
      pslverr = pready & err_q;
      we      = pready & wr_q & ~err_q;
      prdata  = (pready & ~wr_q) ? rd_q : prdata_q;
   end

   // capture the request in setup; retire a read into prdata
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q   <= '0;
         wd_q     <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= '0;
         prdata_q <= '0;
      end else begin
         if (cur == SETUP) begin
            addr_q <= addr;
            wd_q   <= pwdata;
            wr_q   <= pwrite;
            err_q  <= err_c;
            rd_q   <= rdata;
         end
         if (pready && !wr_q) begin
            prdata_q <= rd_q;
         end
      end
   end

   apb_regbank #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NREG    (NREG),
      .RO_MASK (RO_MASK)
   ) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (addr_q),
      .wdata (wd_q),
      .raddr (addr),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_apb_regfile.sv
// Testbench for apb_regfile: directed APB transfers.
// Expected responses queued by stimulus, checked by a monitor.
module tb_apb_regfile;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NR = 16;
   localparam int WC = 2;
`ifdef APB_REGFILE_WAIT_EN
   localparam int LAT  = WC + 2;
   localparam int DROP = 1;
`else
   localparam int LAT  = 2;
   localparam int DROP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] addr;
   logic [DW-1:0] pwdata;
   logic          pwrite;
   logic          psel;
   logic          penable;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   typedef struct {
      logic          err;
      logic [DW-1:0] rd;
      string         tag;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   int            tests = 0;
   int            fails = 0;
   int            hits;
   logic [DW-1:0] last_rd;

   always #5 clk = ~clk;

   apb_regfile #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NREG     (NR),
      .RO_MASK  (16'h0001),
      .WAIT_CYC (WC)
   ) dut (
      .clk     (clk),
      .reset   (rst_n),
      .addr    (addr),
      .pwdata  (pwdata),
      .pwrite  (pwrite),
      .psel    (psel),
      .penable (penable),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // monitor: every completed transfer must match the queue head
   always @(negedge clk) begin
      if (pready === 1'b1) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pready: prdata=%h pslverr=%b",
                     prdata, pslverr);
         end else begin
            e = sb.pop_front();
            if (pslverr !== e.err || prdata !== e.rd) begin
               fails++;
               $display("FAIL %s: pslverr=%b prdata=%h want %b %h",
                        e.tag, pslverr, prdata, e.err, e.rd);
            end
         end
      end
   end

   task automatic idle();
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input string tag, input logic w,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input logic eerr,
                       input logic [DW-1:0] erd);
      int   n;
      bit   ok;
      exp_t x;
      x.err = eerr;
      x.tag = tag;
      if (w) begin
         x.rd = last_rd;
      end else begin
         x.rd    = erd;
         last_rd = erd;
      end
      sb.push_back(x);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = w;
      addr    = a;
      pwdata  = d;
      @(posedge clk);
      #1;
      penable = 1'b1;
      pwrite  = ~w;
      addr    = ~a;
      pwdata  = ~d;
      n  = 2;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (pready === 1'b1) ok = 1'b1;
         else n++;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: no pready in 20 cycles", tag);
      end else begin
         chk({tag, "_lat"}, n, LAT);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      addr    = '0;
      pwdata  = '0;
      last_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_prdata", prdata, 0);
      chk("rst_pready", pready, 0);
      chk("rst_pslverr", pslverr, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      xfer("wr6", 1, 6, 8'h04, 0, 0);
      xfer("rd6", 0, 6, 8'h00, 0, 8'h04);
      idle();

      xfer("wr16", 1, 16, 8'hAA, 1, 0);
      xfer("rd16", 0, 16, 8'h00, 1, 8'h00);
      xfer("rd6b", 0, 6, 8'h00, 0, 8'h04);
      xfer("rd0a", 0, 0, 8'h00, 0, 8'h00);
      xfer("wr0ro", 1, 0, 8'h55, 1, 0);
      xfer("rd0ro", 0, 0, 8'h00, 0, 8'h00);
      idle();

      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      addr    = 8'd7;
      pwdata  = 8'h99;
      hits    = 0;
      repeat (2) begin
         @(negedge clk);
         if (pready === 1'b1) hits++;
         @(posedge clk);
         #1;
      end
      chk("stray_penable_pready", hits, 0);
      idle();
      xfer("rd7", 0, 7, 8'h00, 0, 8'h00);
      idle();

      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      addr    = 8'd3;
      pwdata  = 8'h33;
      @(posedge clk);
      #1;
      penable = 1'b1;
      hits    = 0;
      repeat (DROP) begin
         @(negedge clk);
         if (pready === 1'b1) hits++;
         @(posedge clk);
         #1;
      end
      psel    = 1'b0;
      penable = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (pready === 1'b1) hits++;
         @(posedge clk);
         #1;
      end
      chk("abort_pready", hits, 0);
      xfer("rd3", 0, 3, 8'h00, 0, 8'h00);
      idle();

      xfer("b2b_wr1", 1, 1, 8'h11, 0, 0);
      xfer("b2b_wr2", 1, 2, 8'h22, 0, 0);
      xfer("b2b_rd1", 0, 1, 8'h00, 0, 8'h11);
      xfer("b2b_rd2", 0, 2, 8'h00, 0, 8'h22);
      idle();

      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      addr    = 8'd5;
      pwdata  = 8'h7F;
      @(posedge clk);
      #1;
      penable = 1'b1;
      repeat (WC * DROP) @(posedge clk);
      #1;
      chk("rstmid_pready_pre", pready, 1);
      chk("rstmid_prdata_pre", prdata, 8'h22);
      rst_n = 1'b0;
      #1;
      chk("rstmid_prdata", prdata, 0);
      chk("rstmid_pready", pready, 0);
      chk("rstmid_pslverr", pslverr, 0);
      psel    = 1'b0;
      penable = 1'b0;
      last_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      xfer("rd5_after_rst", 0, 5, 8'h00, 0, 8'h00);
      xfer("rd1_after_rst", 0, 1, 8'h00, 0, 8'h00);
      idle();
      idle();

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
